status_panel_rx: RTL and testbench

STATUS_PANEL_RX -- requirements
Module: status_panel_rx

---
 rtl/status_panel_rx.sv | 161 ++++++++++++++++
 tb/tb_status_panel_rx.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/status_panel_rx.sv
// Status panel receiver: detects status-code changes from the home controller,
// queues them in a 4-deep FIFO and shows each on a 7-segment digit for DWELL cycles.
module status_panel_rx #(
   parameter int DWELL = 8
) (
   input  logic       clk,
   input  logic       Rst,
   input  logic [2:0] display,
   input  logic       ack,
   output logic [2:0] event_id,
   output logic [6:0] seg,
   output logic       busy,
   output logic       fire_latch,
   output logic       overflow,
   output logic       err,
   output logic [7:0] evt_count
);

   typedef enum logic [0:0] {IDLE = 1'b0, SHOW = 1'b1} state_t;

   localparam logic [7:0] DWELL_LOAD = 8'(DWELL - 1);

   // Active-high segments {g,f,e,d,c,b,a}; codes 6-7 never reach the display.
   function automatic logic [6:0] seg_decode(input logic [2:0] code);
      logic [6:0] s;
      case (code)
         3'd0:    s = 7'h3F;
         3'd1:    s = 7'h06;
         3'd2:    s = 7'h5B;
         3'd3:    s = 7'h4F;
         3'd4:    s = 7'h66;
         3'd5:    s = 7'h6D;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   state_t     state_r, state_nxt_s;
   logic [7:0] dwell_r, dwell_nxt_s;
   logic [2:0] event_id_r, event_id_nxt_s;
   logic [6:0] seg_r;
   logic [2:0] prev_r;
   logic [2:0] mem_r [4];
   logic [1:0] wr_ptr_r, rd_ptr_r;
   logic [2:0] count_r;
   logic       fire_r, overflow_r, err_r;
   logic [7:0] evt_count_r;

   logic       chg_s, push_s, illegal_s, pop_s, accept_s;
   logic [2:0] head_s;

   assign chg_s     = (display != prev_r);
   assign push_s    = chg_s && (display >= 3'd1) && (display <= 3'd5);
   assign illegal_s = chg_s && (display >= 3'd6);
   assign head_s    = mem_r[rd_ptr_r];
   // A push into a full FIFO still fits if the head leaves on the same edge.
   assign accept_s  = push_s && ((count_r != 3'd4) || pop_s);

   // Next-state, pop decision and next displayed code.
   always_comb begin
      state_nxt_s    = state_r;
      dwell_nxt_s    = dwell_r;
      event_id_nxt_s = event_id_r;
      pop_s          = 1'b0;
      case (state_r)
         IDLE: begin
            if (count_r != 3'd0) begin
               pop_s          = 1'b1;
               event_id_nxt_s = head_s;
               dwell_nxt_s    = DWELL_LOAD;
               state_nxt_s    = SHOW;
            end else begin
               event_id_nxt_s = 3'd0;
            end
         end
         SHOW: begin
            if (dwell_r != 8'd0) begin
               dwell_nxt_s = dwell_r - 8'd1;
            end else if (count_r != 3'd0) begin
               pop_s          = 1'b1;
               event_id_nxt_s = head_s;
               dwell_nxt_s    = DWELL_LOAD;
            end else begin
               event_id_nxt_s = 3'd0;
               state_nxt_s    = IDLE;
            end
         end
         default: begin
            event_id_nxt_s = 3'd0;
            dwell_nxt_s    = 8'd0;
            state_nxt_s    = IDLE;
         end
      endcase
   end

   // FSM, FIFO bookkeeping and sticky status registers.
   always_ff @(posedge clk) begin
      if (Rst) begin
         state_r     <= IDLE;
         dwell_r     <= 8'd0;
         event_id_r  <= 3'd0;
         seg_r       <= 7'h3F;
         prev_r      <= 3'd0;
         wr_ptr_r    <= 2'd0;
         rd_ptr_r    <= 2'd0;
         count_r     <= 3'd0;
         fire_r      <= 1'b0;
         overflow_r  <= 1'b0;
         err_r       <= 1'b0;
         evt_count_r <= 8'd0;
      end else begin
         state_r    <= state_nxt_s;
         dwell_r    <= dwell_nxt_s;
         event_id_r <= event_id_nxt_s;
         seg_r      <= seg_decode(event_id_nxt_s);
         prev_r     <= display;
         if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + 2'd1;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + 2'd1;
         end
         case ({accept_s, pop_s})
            2'b10:   count_r <= count_r + 3'd1;
            2'b01:   count_r <= count_r - 3'd1;
            default: count_r <= count_r;
         endcase
         if (accept_s && (evt_count_r != 8'd255)) begin
            evt_count_r <= evt_count_r + 8'd1;
         end
         if (push_s && !accept_s) begin
            overflow_r <= 1'b1;
         end
         if (illegal_s) begin
            err_r <= 1'b1;
         end
         // A fire push (even a dropped one) beats a simultaneous acknowledge.
         if (push_s && (display == 3'd3)) begin
            fire_r <= 1'b1;
         end else if (ack) begin
            fire_r <= 1'b0;
         end
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (!Rst && accept_s) begin
         mem_r[wr_ptr_r] <= display;
      end
   end

   assign event_id   = event_id_r;
   assign seg        = seg_r;
   assign busy       = (state_r == SHOW);
   assign fire_latch = fire_r;
   assign overflow   = overflow_r;
   assign err        = err_r;
   assign evt_count  = evt_count_r;

endmodule

// File: tb/tb_status_panel_rx.sv
// Directed bench for status_panel_rx (DWELL=8) with hand-computed expectations.
module tb_status_panel_rx;

   logic       clk = 1'b0;
   logic       Rst;
   logic [2:0] display;
   logic       ack;
   logic [2:0] event_id;
   logic [6:0] seg;
   logic       busy, fire_latch, overflow, err;
   logic [7:0] evt_count;

   int n_checks = 0;
   int n_errors = 0;

   status_panel_rx #(.DWELL(8)) dut (
      .clk(clk), .Rst(Rst), .display(display), .ack(ack),
      .event_id(event_id), .seg(seg), .busy(busy), .fire_latch(fire_latch),
      .overflow(overflow), .err(err), .evt_count(evt_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [2:0] disp);
      Rst = 1'b1; display = disp; ack = 1'b0;
      tick();
      Rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".event_id"}, 32'(event_id), 32'd0);
      check({tag, ".seg"}, 32'(seg), 32'h3F);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".flags"}, 32'({fire_latch, overflow, err}), 32'd0);
      check({tag, ".evt_count"}, 32'(evt_count), 32'd0);
   endtask

   logic [2:0] exp_id;
   int         busy_cycles;
   logic [2:0] codes [4];

   initial begin
      Rst = 1'b1; display = 3'd0; ack = 1'b0;
      tick();
      tick();
      check_reset_state("reset");

      // Single event: visible after the 2nd edge, shown for 8 cycles.
      Rst = 1'b0;
      display = 3'd1;
      tick();
      display = 3'd0;
      check("single.edge1_id", 32'(event_id), 32'd0);
      tick();
      check("single.edge2_id", 32'(event_id), 32'd1);
      check("single.edge2_seg", 32'(seg), 32'h06);
      check("single.edge2_busy", 32'(busy), 32'd1);
      for (int k = 3; k <= 9; k++) tick();
      check("single.edge9_id", 32'(event_id), 32'd1);
      check("single.edge9_busy", 32'(busy), 32'd1);
      tick();
      check("single.edge10_id", 32'(event_id), 32'd0);
      check("single.edge10_seg", 32'(seg), 32'h3F);
      check("single.edge10_busy", 32'(busy), 32'd0);
      check("single.evt_count", 32'(evt_count), 32'd1);

      // Held code, also held across the reset release: exactly one push.
      do_reset(3'd4);
      check("held.in_reset_count", 32'(evt_count), 32'd0);
      for (int k = 0; k < 50; k++) tick();
      check("held.evt_count", 32'(evt_count), 32'd1);
      check("held.idle_id", 32'(event_id), 32'd0);
      check("held.idle_busy", 32'(busy), 32'd0);

      // Back-to-back queue: 1,2,4,5 shown 8 cycles each with no gap.
      do_reset(3'd0);
      codes[0] = 3'd1; codes[1] = 3'd2; codes[2] = 3'd4; codes[3] = 3'd5;
      busy_cycles = 0;
      for (int k = 1; k <= 40; k++) begin
         display = (k <= 4) ? codes[k-1] : 3'd0;
         tick();
         if (busy) busy_cycles++;
         if (k >= 2 && k <= 33) exp_id = codes[(k-2)/8];
         else exp_id = 3'd0;
         check($sformatf("b2b.id_e%0d", k), 32'(event_id), 32'(exp_id));
      end
      check("b2b.busy_cycles", busy_cycles, 32'd32);
      check("b2b.evt_count", 32'(evt_count), 32'd4);

      // Overflow: six changes, the 6th arrives with the FIFO full and no pop.
      do_reset(3'd0);
      display = 3'd1; tick();
      display = 3'd2; tick();
      display = 3'd4; tick();
      display = 3'd5; tick();
      display = 3'd1; tick();
      check("ovf.before", 32'(overflow), 32'd0);
      display = 3'd2; tick();
      display = 3'd0;
      check("ovf.flag", 32'(overflow), 32'd1);
      check("ovf.evt_count", 32'(evt_count), 32'd5);
      for (int k = 7; k <= 10; k++) tick();
      check("ovf.second_shown", 32'(event_id), 32'd2);
      check("ovf.second_seg", 32'(seg), 32'h5B);

      // Fire with ack at the push edge: set wins; a later bare ack clears.
      do_reset(3'd0);
      display = 3'd3; ack = 1'b1;
      tick();
      display = 3'd0; ack = 1'b0;
      check("fire.set_wins", 32'(fire_latch), 32'd1);
      tick();
      check("fire.held", 32'(fire_latch), 32'd1);
      check("fire.shown_seg", 32'(seg), 32'h4F);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      check("fire.cleared", 32'(fire_latch), 32'd0);

      // Illegal code: sticky err, no push.
      do_reset(3'd0);
      display = 3'd7; tick();
      display = 3'd0;
      check("illegal.err", 32'(err), 32'd1);
      check("illegal.evt_count", 32'(evt_count), 32'd0);
      tick(); tick();
      check("illegal.err_sticky", 32'(err), 32'd1);
      check("illegal.no_show", 32'(busy), 32'd0);

      // Reset during SHOW with three queued entries.
      display = 3'd1; tick();
      display = 3'd2; tick();
      display = 3'd4; tick();
      display = 3'd5; tick();
      display = 3'd0;
      check("rst_show.busy", 32'(busy), 32'd1);
      check("rst_show.evt_count", 32'(evt_count), 32'd4);
      Rst = 1'b1;
      tick();
      check_reset_state("rst_show");
      Rst = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("rst_show.discarded_id", 32'(event_id), 32'd0);
      check("rst_show.discarded_busy", 32'(busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
